// File: rtl/cfu_l1_share_arb_if.sv
// ---------------------------------------------------------------------------
// cfu_l1_share_arb_if
// Bundle of every signal between the requesters, the shared-CFU arbiter and
// the shared CFU-L1 itself.
//   rq_*        : per-requester request lanes (lane i at [i*W +: W])
//   rs_*        : per-requester response lanes
//   cfu_req_*   : single request channel toward the shared CFU
//   cfu_resp_*  : fixed-latency response channel from the shared CFU
// Modports:
//   master : environment side (requesters and the CFU)
//   slave  : the arbiter
// ---------------------------------------------------------------------------
interface cfu_l1_share_arb_if #(
    parameter int N_REQ      = 4,
    parameter int FUNC_ID_W  = 10,
    parameter int STATE_ID_W = 8,
    parameter int DATA_W     = 32,
    parameter int STATUS_W   = 3
);
    logic [N_REQ-1:0]            rq_valid;
    logic [N_REQ-1:0]            rq_ready;
    logic [N_REQ*FUNC_ID_W-1:0]  rq_func;
    logic [N_REQ*STATE_ID_W-1:0] rq_state;
    logic [N_REQ*DATA_W-1:0]     rq_data0;
    logic [N_REQ*DATA_W-1:0]     rq_data1;
    logic [N_REQ-1:0]            rs_valid;
    logic [N_REQ*STATUS_W-1:0]   rs_status;
    logic [N_REQ*DATA_W-1:0]     rs_data;
    logic                        cfu_req_valid;
    logic [FUNC_ID_W-1:0]        cfu_req_func;
    logic [STATE_ID_W-1:0]       cfu_req_state;
    logic [DATA_W-1:0]           cfu_req_data0;
    logic [DATA_W-1:0]           cfu_req_data1;
    logic                        cfu_resp_valid;
    logic [STATUS_W-1:0]         cfu_resp_status;
    logic [DATA_W-1:0]           cfu_resp_data;

    modport master (
        output rq_valid, rq_func, rq_state, rq_data0, rq_data1,
        input  rq_ready, rs_valid, rs_status, rs_data,
        input  cfu_req_valid, cfu_req_func, cfu_req_state, cfu_req_data0, cfu_req_data1,
        output cfu_resp_valid, cfu_resp_status, cfu_resp_data
    );

    modport slave (
        input  rq_valid, rq_func, rq_state, rq_data0, rq_data1,
        output rq_ready, rs_valid, rs_status, rs_data,
        output cfu_req_valid, cfu_req_func, cfu_req_state, cfu_req_data0, cfu_req_data1,
        input  cfu_resp_valid, cfu_resp_status, cfu_resp_data
    );
endinterface

// File: rtl/cfu_l1_share_arb.sv
// ---------------------------------------------------------------------------
// cfu_l1_share_arb
// Shares one fixed-latency, stateful CFU-L1 among N_REQ requesters.
// Each enabled cycle one requester is granted round-robin, its local state ID
// is remapped into a private slice of CFU contexts (g*STATES_PER + local),
// and a {valid, tag, lerr} record travels a LAT-deep pipeline so the CFU's
// fixed-latency response is steered back to the originator.
// Ports:
//   clk, rst : clock, synchronous active-high reset (also resets the CFU)
//   clk_en   : global enable; no grants and a frozen pipeline while low
//   bus      : cfu_l1_share_arb_if.slave (requester lanes + CFU channel)
// Requires N_REQ*STATES_PER <= 2**STATE_ID_W and LAT equal to the CFU latency.
// ---------------------------------------------------------------------------

// Latency agreement monitor: the tag pipeline and the CFU must agree on
// which cycles carry a real CFU response.
module cfu_l1_share_arb_chk (
    input logic clk,
    input logic rst,
    input logic pipe_vld,
    input logic pipe_lerr,
    input logic cfu_resp_valid
);
    // Flag a CFU whose latency differs from LAT
    always @(posedge clk) begin
        if (!rst) begin
            assert (cfu_resp_valid == (pipe_vld && !pipe_lerr));
        end
    end
endmodule

module cfu_l1_share_arb #(
    parameter int N_REQ      = 4,
    parameter int STATES_PER = 2,
    parameter int LAT        = 1,
    parameter int FUNC_ID_W  = 10,
    parameter int STATE_ID_W = 8,
    parameter int DATA_W     = 32,
    parameter int STATUS_W   = 3,
    parameter logic [STATUS_W-1:0] CFU_ERROR_STATE = STATUS_W'(2)
) (
    input logic              clk,
    input logic              rst,
    input logic              clk_en,
    cfu_l1_share_arb_if.slave bus
);
    localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [TAG_W-1:0]      rr_ptr_r;
    logic                  grant_vld_s;
    logic [TAG_W-1:0]      grant_idx_s;
    logic [STATE_ID_W-1:0] local_state_s;
    logic                  in_range_s;
    logic                  out_vld_s;
    logic                  out_lerr_s;
    logic [TAG_W-1:0]      out_tag_s;

    // Round-robin scan starting at rr_ptr_r; nothing is granted in reset or while disabled
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        if (clk_en && !rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!grant_vld_s && bus.rq_valid[(int'(rr_ptr_r) + k) % N_REQ]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = TAG_W'((int'(rr_ptr_r) + k) % N_REQ);
                end else begin
                    grant_idx_s = grant_idx_s;
                end
            end
        end else begin
            grant_vld_s = 1'b0;
            grant_idx_s = '0;
        end
    end

    assign local_state_s = bus.rq_state[grant_idx_s*STATE_ID_W +: STATE_ID_W];
    assign in_range_s    = ({1'b0, local_state_s} < (STATE_ID_W+1)'(STATES_PER));

    // One-hot accept to the granted requester (out-of-range states are accepted too)
    always_comb begin
        bus.rq_ready = '0;
        if (grant_vld_s) begin
            bus.rq_ready[grant_idx_s] = 1'b1;
        end else begin
            bus.rq_ready = '0;
        end
    end

    // Forward the granted in-range request with its state remapped into the requester's slice
    always_comb begin
        bus.cfu_req_valid = 1'b0;
        bus.cfu_req_func  = '0;
        bus.cfu_req_state = '0;
        bus.cfu_req_data0 = '0;
        bus.cfu_req_data1 = '0;
        if (grant_vld_s && in_range_s) begin
            bus.cfu_req_valid = 1'b1;
            bus.cfu_req_func  = bus.rq_func[grant_idx_s*FUNC_ID_W +: FUNC_ID_W];
            bus.cfu_req_state = STATE_ID_W'(32'(grant_idx_s) * STATES_PER) + local_state_s;
            bus.cfu_req_data0 = bus.rq_data0[grant_idx_s*DATA_W +: DATA_W];
            bus.cfu_req_data1 = bus.rq_data1[grant_idx_s*DATA_W +: DATA_W];
        end else begin
            bus.cfu_req_valid = 1'b0;
        end
    end

    // Move priority to the requester after the one just served
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (clk_en && grant_vld_s) begin
            rr_ptr_r <= (grant_idx_s == TAG_W'(N_REQ - 1)) ? '0 : grant_idx_s + TAG_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    generate
        if (LAT == 0) begin : g_lat0
            assign out_vld_s  = grant_vld_s;
            assign out_tag_s  = grant_idx_s;
            assign out_lerr_s = grant_vld_s && !in_range_s;
        end else begin : g_pipe
            logic [LAT-1:0]            vld_r;
            logic [LAT-1:0]            lerr_r;
            logic [LAT-1:0][TAG_W-1:0] tag_r;

            // Tag pipeline mirroring the CFU latency; frozen with the CFU while clk_en is low
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_r  <= '0;
                    lerr_r <= '0;
                    tag_r  <= '0;
                end else if (clk_en) begin
                    vld_r[0]  <= grant_vld_s;
                    lerr_r[0] <= grant_vld_s && !in_range_s;
                    tag_r[0]  <= grant_idx_s;
                    for (int i = 1; i < LAT; i++) begin
                        vld_r[i]  <= vld_r[i-1];
                        lerr_r[i] <= lerr_r[i-1];
                        tag_r[i]  <= tag_r[i-1];
                    end
                end else begin
                    vld_r  <= vld_r;
                    lerr_r <= lerr_r;
                    tag_r  <= tag_r;
                end
            end

            assign out_vld_s  = vld_r[LAT-1];
            assign out_tag_s  = tag_r[LAT-1];
            assign out_lerr_s = lerr_r[LAT-1];
        end
    endgenerate

    // Steer the pipeline head to its requester lane; locally rejected states answer with an error
    always_comb begin
        bus.rs_valid  = '0;
        bus.rs_status = '0;
        bus.rs_data   = '0;
        if (out_vld_s && !rst) begin
            bus.rs_valid[out_tag_s] = 1'b1;
            if (out_lerr_s) begin
                bus.rs_status[out_tag_s*STATUS_W +: STATUS_W] = CFU_ERROR_STATE;
            end else begin
                bus.rs_status[out_tag_s*STATUS_W +: STATUS_W] = bus.cfu_resp_status;
                bus.rs_data[out_tag_s*DATA_W +: DATA_W]       = bus.cfu_resp_data;
            end
        end else begin
            bus.rs_valid = '0;
        end
    end

    cfu_l1_share_arb_chk u_chk (
        .clk            (clk),
        .rst            (rst),
        .pipe_vld       (out_vld_s),
        .pipe_lerr      (out_lerr_s),
        .cfu_resp_valid (bus.cfu_resp_valid)
    );
endmodule

// File: tb/tb_cfu_l1_share_arb.sv
// ---------------------------------------------------------------------------
// tb_cfu_l1_share_arb
// Two arbiters (LAT=1 and LAT=2), each in front of a behavioural mul/mulacc
// CFU (func 0 = mul, func 1 = mulacc into the addressed context). Expected
// responses are queued when a request is driven and matched when rs_valid
// rises.
// ---------------------------------------------------------------------------
module tb_cfu_l1_share_arb;
    localparam logic [2:0] ST_OK  = 3'd0;
    localparam logic [2:0] ST_ERR = 3'd2;

    typedef struct {
        int          req;
        logic [2:0]  st;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    logic [1:0] ce;
    logic [1:0][3:0]   rqv;
    logic [1:0][39:0]  rqf;
    logic [1:0][31:0]  rqs;
    logic [1:0][127:0] rqa;
    logic [1:0][127:0] rqb;
    int checks;
    int errors;
    int cyc;
    exp_t q0[$];
    exp_t q1[$];

    cfu_l1_share_arb_if bus1 ();
    cfu_l1_share_arb_if bus2 ();

    cfu_l1_share_arb #(.LAT(1)) dut1 (.clk(clk), .rst(rst), .clk_en(ce[0]), .bus(bus1));
    cfu_l1_share_arb #(.LAT(2)) dut2 (.clk(clk), .rst(rst), .clk_en(ce[1]), .bus(bus2));

    assign bus1.rq_valid = rqv[0];
    assign bus1.rq_func  = rqf[0];
    assign bus1.rq_state = rqs[0];
    assign bus1.rq_data0 = rqa[0];
    assign bus1.rq_data1 = rqb[0];
    assign bus2.rq_valid = rqv[1];
    assign bus2.rq_func  = rqf[1];
    assign bus2.rq_state = rqs[1];
    assign bus2.rq_data0 = rqa[1];
    assign bus2.rq_data1 = rqb[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CFU, latency 1
    logic [31:0] acc1 [8];
    always_ff @(posedge clk) begin
        if (rst) begin
            bus1.cfu_resp_valid  <= 1'b0;
            bus1.cfu_resp_status <= 3'd0;
            bus1.cfu_resp_data   <= 32'd0;
            for (int i = 0; i < 8; i++) acc1[i] <= 32'd0;
        end else if (ce[0]) begin
            bus1.cfu_resp_valid  <= bus1.cfu_req_valid;
            bus1.cfu_resp_status <= ST_OK;
            if (bus1.cfu_req_valid && bus1.cfu_req_func == 10'd1) begin
                acc1[bus1.cfu_req_state[2:0]] <= acc1[bus1.cfu_req_state[2:0]] + bus1.cfu_req_data0 * bus1.cfu_req_data1;
                bus1.cfu_resp_data <= acc1[bus1.cfu_req_state[2:0]] + bus1.cfu_req_data0 * bus1.cfu_req_data1;
            end else begin
                bus1.cfu_resp_data <= bus1.cfu_req_data0 * bus1.cfu_req_data1;
            end
        end
    end

    // Behavioural CFU, latency 2
    logic [31:0] acc2 [8];
    logic        m2_vld;
    logic [31:0] m2_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            m2_vld <= 1'b0;
            m2_data <= 32'd0;
            bus2.cfu_resp_valid  <= 1'b0;
            bus2.cfu_resp_status <= 3'd0;
            bus2.cfu_resp_data   <= 32'd0;
            for (int i = 0; i < 8; i++) acc2[i] <= 32'd0;
        end else if (ce[1]) begin
            m2_vld <= bus2.cfu_req_valid;
            if (bus2.cfu_req_valid && bus2.cfu_req_func == 10'd1) begin
                acc2[bus2.cfu_req_state[2:0]] <= acc2[bus2.cfu_req_state[2:0]] + bus2.cfu_req_data0 * bus2.cfu_req_data1;
                m2_data <= acc2[bus2.cfu_req_state[2:0]] + bus2.cfu_req_data0 * bus2.cfu_req_data1;
            end else begin
                m2_data <= bus2.cfu_req_data0 * bus2.cfu_req_data1;
            end
            bus2.cfu_resp_valid  <= m2_vld;
            bus2.cfu_resp_status <= ST_OK;
            bus2.cfu_resp_data   <= m2_data;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int k, input int i, input logic [9:0] f, input logic [7:0] s,
                       input logic [31:0] a, input logic [31:0] b);
        rqv[k][i] = 1'b1;
        rqf[k][i*10 +: 10] = f;
        rqs[k][i*8 +: 8]   = s;
        rqa[k][i*32 +: 32] = a;
        rqb[k][i*32 +: 32] = b;
    endtask

    task automatic push(input int k, input int r, input logic [2:0] st, input logic [31:0] d, input int due);
        exp_t e;
        e.req = r; e.st = st; e.data = d; e.due = due;
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic req_chk(input int k, input string tag, input logic [3:0] rdy, input logic cv,
                           input logic [7:0] cst, input logic [31:0] cd0);
        if (k == 0) begin
            chk({tag, "_ready"}, 128'(bus1.rq_ready), 128'(rdy));
            chk({tag, "_cfu_valid"}, 128'(bus1.cfu_req_valid), 128'(cv));
            chk({tag, "_cfu_state"}, 128'(bus1.cfu_req_state), 128'(cst));
            chk({tag, "_cfu_data0"}, 128'(bus1.cfu_req_data0), 128'(cd0));
        end else begin
            chk({tag, "_ready"}, 128'(bus2.rq_ready), 128'(rdy));
            chk({tag, "_cfu_valid"}, 128'(bus2.cfu_req_valid), 128'(cv));
            chk({tag, "_cfu_state"}, 128'(bus2.cfu_req_state), 128'(cst));
            chk({tag, "_cfu_data0"}, 128'(bus2.cfu_req_data0), 128'(cd0));
        end
    endtask

    task automatic observe(input int k);
        logic [3:0]   rv;
        logic [11:0]  rs;
        logic [127:0] rd;
        exp_t e;
        int n;
        rv = (k == 0) ? bus1.rs_valid  : bus2.rs_valid;
        rs = (k == 0) ? bus1.rs_status : bus2.rs_status;
        rd = (k == 0) ? bus1.rs_data   : bus2.rs_data;
        n  = (k == 0) ? q0.size() : q1.size();
        if (rv != 4'b0) begin
            if (n == 0) begin
                chk("rs_spurious", 128'(rv), 128'(0));
            end else begin
                if (k == 0) e = q0.pop_front();
                else e = q1.pop_front();
                chk("rs_valid", 128'(rv), 128'(4'b1 << e.req));
                chk("rs_status", 128'(rs), 128'(12'(e.st) << (3*e.req)));
                chk("rs_data", rd, 128'(e.data) << (32*e.req));
                chk("rs_cycle", 128'(cyc), 128'(e.due));
            end
        end else if (n != 0) begin
            e = (k == 0) ? q0[0] : q1[0];
            if (e.due <= cyc) begin
                chk("rs_missing", 128'(rv), 128'(4'b1 << e.req));
                if (k == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        observe(0);
        observe(1);
        tick();
    endtask

    task automatic idle_cycle();
        #1;
        finish_cycle();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1; ce = 2'b11;
        rqv = '0; rqf = '0; rqs = '0; rqa = '0; rqb = '0;

        // Reset: all requesters valid, nothing accepted, nothing returned
        @(negedge clk);
        rqv[0] = 4'hF; rqv[1] = 4'hF;
        tick();
        #1;
        chk("rst_ready1", 128'(bus1.rq_ready), 128'(0));
        chk("rst_ready2", 128'(bus2.rq_ready), 128'(0));
        chk("rst_cfu_valid1", 128'(bus1.cfu_req_valid), 128'(0));
        chk("rst_rs_valid1", 128'(bus1.rs_valid), 128'(0));
        chk("rst_rs_valid2", 128'(bus2.rs_valid), 128'(0));
        tick();
        rst = 1'b0; rqv = '0;

        // All four requesters valid for 8 cycles: grants 0,1,2,3,0,1,2,3
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++) drv(0, i, 10'd0, 8'(i % 2), 32'(i + 1), 32'(c + 3));
            #1;
            req_chk(0, "rr", 4'(1 << (c % 4)), 1'b1, 8'((c % 4) * 2 + (c % 2)), 32'((c % 4) + 1));
            push(0, c % 4, ST_OK, 32'(((c % 4) + 1) * (c + 3)), cyc + 1);
            finish_cycle();
        end
        rqv[0] = 4'h0;
        idle_cycle();

        // Single request from requester 2: state 1 -> context 5, 6*7
        drv(0, 2, 10'd0, 8'd1, 32'd6, 32'd7);
        #1;
        req_chk(0, "single", 4'b0100, 1'b1, 8'd5, 32'd6);
        push(0, 2, ST_OK, 32'd42, cyc + 1);
        finish_cycle();
        rqv[0] = 4'h0;
        idle_cycle();

        // Out-of-range state from requester 1, requester 2 in range behind it
        drv(0, 1, 10'd0, 8'd2, 32'd9, 32'd9);
        drv(0, 2, 10'd0, 8'd1, 32'd5, 32'd5);
        #1;
        req_chk(0, "lerr", 4'b0010, 1'b0, 8'd0, 32'd0);
        push(0, 1, ST_ERR, 32'd0, cyc + 1);
        finish_cycle();
        rqv[0][1] = 1'b0;
        #1;
        req_chk(0, "after_lerr", 4'b0100, 1'b1, 8'd5, 32'd5);
        push(0, 2, ST_OK, 32'd25, cyc + 1);
        finish_cycle();
        rqv[0] = 4'h0;
        idle_cycle();

        // Isolation: requesters 0 and 1 both mulacc into their local state 0
        for (int n = 0; n < 4; n++) begin
            rqv[0] = 4'h0;
            drv(0, n % 2, 10'd1, 8'd0, 32'(3 - (n % 2)), 32'(3 - (n % 2)));
            #1;
            req_chk(0, "iso", 4'(1 << (n % 2)), 1'b1, 8'((n % 2) * 2), 32'(3 - (n % 2)));
            push(0, n % 2, ST_OK, 32'((3 - (n % 2)) * (3 - (n % 2)) * (n / 2 + 1)), cyc + 1);
            finish_cycle();
        end
        rqv[0] = 4'h0;
        idle_cycle();

        // LAT=2: request from requester 1, then clk_en low for 3 cycles
        drv(1, 1, 10'd0, 8'd1, 32'd3, 32'd4);
        #1;
        req_chk(1, "fz_pre", 4'b0010, 1'b1, 8'd3, 32'd3);
        push(1, 1, ST_OK, 32'd12, cyc + 5);
        finish_cycle();
        ce[1] = 1'b0;
        for (int i = 0; i < 4; i++) drv(1, i, 10'd0, 8'd0, 32'(i + 3), 32'd6);
        for (int n = 0; n < 3; n++) begin
            #1;
            req_chk(1, "fz", 4'b0000, 1'b0, 8'd0, 32'd0);
            finish_cycle();
        end
        ce[1] = 1'b1;
        #1;
        req_chk(1, "fz_resume", 4'b0100, 1'b1, 8'd4, 32'd5);
        push(1, 2, ST_OK, 32'd30, cyc + 2);
        finish_cycle();
        rqv[1] = 4'h0;
        for (int n = 0; n < 3; n++) idle_cycle();

        // LAT=2: reset with a request in flight; it must vanish and priority restarts at 0
        drv(1, 0, 10'd0, 8'd0, 32'd7, 32'd7);
        #1;
        req_chk(1, "pre_rst", 4'b0001, 1'b1, 8'd0, 32'd7);
        finish_cycle();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) drv(1, i, 10'd0, 8'd0, 32'(i + 2), 32'd5);
        #1;
        req_chk(1, "in_rst", 4'b0000, 1'b0, 8'd0, 32'd0);
        finish_cycle();
        rst = 1'b0;
        #1;
        req_chk(1, "post_rst", 4'b0001, 1'b1, 8'd0, 32'd2);
        push(1, 0, ST_OK, 32'd10, cyc + 2);
        finish_cycle();
        rqv[1] = 4'h0;
        for (int n = 0; n < 4; n++) idle_cycle();

        chk("drain_q0", 128'(q0.size()), 128'(0));
        chk("drain_q1", 128'(q1.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cfu_l1_share_arb.md
Name: cfu_l1_share_arb

Overview:
- Shares one fixed-latency stateful CFU-L1 (e.g. a mul/mulacc unit) among N_REQ requesters (harts or accelerator ports).
- Each cycle, grants at most one requester round-robin and forwards its request to the CFU.
- Remaps each requester's local state ID into a private slice of the CFU's state contexts, so requesters cannot touch each other's accumulators.
- Tags in-flight requests through a LAT-deep pipeline and steers each fixed-latency response back to its originator.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- STATES_PER, 2, state contexts per requester; CFU must have N_REQ*STATES_PER contexts.
- LAT, 1, CFU fixed latency in cycles (0 allowed); must equal the shared CFU's latency.
- FUNC_ID_W, 10, function ID width.
- STATE_ID_W, 8, local and CFU state ID width; must satisfy N_REQ*STATES_PER <= 2**STATE_ID_W.
- DATA_W, 32, operand/result width.
- STATUS_W, 3, CFU status width (cfu_pkg status codes).

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset.
- clk_en, in, 1: global clock enable; also gates the CFU.
- rq_valid, in, N_REQ: per-requester request valid.
- rq_ready, out, N_REQ: per-requester accept (one-hot or zero).
- rq_func, in, N_REQ*FUNC_ID_W: function ID.
- rq_state, in, N_REQ*STATE_ID_W: local state ID.
- rq_data0, in, N_REQ*DATA_W: operand 0.
- rq_data1, in, N_REQ*DATA_W: operand 1.
- rs_valid, out, N_REQ: response valid.
- rs_status, out, N_REQ*STATUS_W: response status.
- rs_data, out, N_REQ*DATA_W: response data.
- cfu_req_valid, out, 1: request valid to the CFU.
- cfu_req_func, out, FUNC_ID_W: forwarded function ID.
- cfu_req_state, out, STATE_ID_W: remapped state ID.
- cfu_req_data0, out, DATA_W: forwarded operand 0.
- cfu_req_data1, out, DATA_W: forwarded operand 1.
- cfu_resp_valid, in, 1: CFU response valid.
- cfu_resp_status, in, STATUS_W: CFU response status.
- cfu_resp_data, in, DATA_W: CFU response data.

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset state:
  - rr_ptr = 0, so requester 0 has highest priority.
  - Tag/valid/local-error pipeline cleared.
  - rs_valid = 0; rq_ready = 0 while rst.
- Arbitration (combinational, per cycle):
  - When clk_en=1, grant the first i with rq_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod N_REQ.
  - rq_ready = one-hot(grant); no grant while clk_en=0.
  - Grant is not sticky; requesters need not hold valid across cycles.
  - On an accepted grant to g: rr_ptr <= (g+1) mod N_REQ at the clk_en edge.
  - No request: rr_ptr holds.
- State remap, when rq_state[g] < STATES_PER:
  - cfu_req_valid = 1.
  - cfu_req_state = g*STATES_PER + rq_state[g].
  - func/data0/data1 passed through unchanged.
- Out-of-range local state (>= STATES_PER):
  - Still accepted (rq_ready=1), but cfu_req_valid = 0.
  - Request flagged lerr in the pipeline.
  - Response returns CFU_ERROR_STATE with data 0 at the normal latency; CFU contexts untouched.
- cfu_req_func/state/data outputs when cfu_req_valid=0: don't-care, driven 0.
- Pipeline: LAT-stage shift register of {valid, tag[clog2(N_REQ)], lerr}, advancing only when clk_en=1. LAT=0 makes it wires.
- Response routing:
  - On stage output valid, rs_valid[tag] = 1; all other rs_valid = 0.
  - lerr=0: rs_status/rs_data[tag] = cfu_resp_status/data.
  - lerr=1: CFU_ERROR_STATE / 0.
  - Latency: a request accepted in cycle t responds in cycle t+LAT (same cycle if LAT=0).
  - Non-target rs_data/rs_status lanes are driven 0.
- Consistency check: pipeline valid with lerr=0 but cfu_resp_valid=0 (or the reverse) means a latency mismatch. Assertion fires in simulation; output is still driven from the pipeline tag.
- Throughput: one request per enabled cycle, full pipelining, no bubbles.
- clk_en=0: no grants, pipeline and rr_ptr frozen, responses hold their current combinational values.
- Reset mid-operation: in-flight requests are dropped and no responses are produced for them. The CFU is reset by the same rst.

Test Plan:
- Single requester, LAT=1: req 2 sends func=0, state=1, data0=6, data1=7 at cycle 0 -> cfu_req_state=5; rs_valid[2]=1 with data 42, status OK at cycle 1.
- All 4 requesters valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; each rs_valid lands on the matching requester exactly 1 cycle later.
- Requester 1 sends state=2 (>= STATES_PER) -> rq_ready[1]=1, cfu_req_valid=0, then rs_status[1]=CFU_ERROR_STATE, rs_data=0 next cycle. A concurrent in-range request granted next is unaffected.
- Isolation: req 0 sends mulacc state 0 with 3*3 twice, interleaved with req 1 sending mulacc state 0 with 2*2 -> req 0 sees 9, 18; req 1 sees 4, 8.
- clk_en low for 3 cycles with request in flight -> no grants, no new rs_valid; response appears 1 enabled cycle after clk_en returns, and rr_ptr is unchanged.
- rst asserted while 1 request is in flight (LAT=2) -> no rs_valid after reset; the next grant goes to requester 0 when all requesters are valid.
